// File: rtl/triple_accum_if.sv
// Sample-in / frame-result-out handshake bundle for triple_accum.
interface triple_accum_if #(
   parameter int unsigned SUM_W = 10
);
   logic             in_valid;
   logic             in_ready;
   logic [5:0]       in_data;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [SUM_W-1:0] out_sum;
   logic [3:0]       out_count;
   logic             out_overflow;

   // Producer of samples and consumer of frame results
   modport master (
      output in_valid, in_data, flush, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_overflow
   );

   // Accumulator side
   modport slave (
      input  in_valid, in_data, flush, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_overflow
   );
endinterface

// File: rtl/triple_accum.sv
// Frame accumulator for triple results: saturating sum of up to N_SAMPLES
// samples per frame, closed early by flush, presented on a registered port.
module triple_accum #(
   parameter int unsigned N_SAMPLES = 4,
   parameter int unsigned SUM_W     = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   triple_accum_if.slave  bus
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned EXT_W = SUM_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES);
   localparam logic [SUM_W-1:0] SUM_MAX  = '1;

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [SUM_W-1:0]   r_acc;
   logic [SUM_W-1:0]   w_acc_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_ovf;
   logic               w_ovf_nxt;
   logic               r_out_valid;
   logic               w_out_valid_nxt;
   logic [SUM_W-1:0]   r_out_sum;
   logic [SUM_W-1:0]   w_out_sum_nxt;
   logic [CNT_W-1:0]   r_out_count;
   logic [CNT_W-1:0]   w_out_count_nxt;
   logic               r_out_ovf;
   logic               w_out_ovf_nxt;

   logic               w_accept;
   logic [EXT_W-1:0]   w_sum_ext;
   logic               w_sat;
   logic [SUM_W-1:0]   w_acc_upd;
   logic [CNT_W-1:0]   w_cnt_upd;
   logic               w_ovf_upd;
   logic               w_close;

   // Sample acceptance and post-accept accumulator values (carry bit flags saturation)
   assign w_accept  = bus.in_valid & (r_state == ST_ACCUM);
   assign w_sum_ext = EXT_W'(r_acc) + EXT_W'(bus.in_data);
   assign w_sat     = w_sum_ext[SUM_W];
   assign w_acc_upd = w_accept ? (w_sat ? SUM_MAX : w_sum_ext[SUM_W-1:0]) : r_acc;
   assign w_cnt_upd = w_accept ? CNT_W'(r_cnt + CNT_W'(1)) : r_cnt;
   assign w_ovf_upd = r_ovf | (w_accept & w_sat);

   // Frame closes on the last sample, or on flush once the frame holds anything
   assign w_close   = (w_accept && (w_cnt_upd == CNT_LAST)) ||
                      (bus.flush && (w_cnt_upd != '0));

   // Next-state and next-register decode
   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_cnt_nxt       = r_cnt;
      w_ovf_nxt       = r_ovf;
      w_out_valid_nxt = r_out_valid;
      w_out_sum_nxt   = r_out_sum;
      w_out_count_nxt = r_out_count;
      w_out_ovf_nxt   = r_out_ovf;

      case (r_state)
         ST_ACCUM: begin
            if (w_close) begin
               w_out_sum_nxt   = w_acc_upd;
               w_out_count_nxt = w_cnt_upd;
               w_out_ovf_nxt   = w_ovf_upd;
               w_out_valid_nxt = 1'b1;
               w_acc_nxt       = '0;
               w_cnt_nxt       = '0;
               w_ovf_nxt       = 1'b0;
               w_state_nxt     = ST_DONE;
            end else begin
               w_acc_nxt = w_acc_upd;
               w_cnt_nxt = w_cnt_upd;
               w_ovf_nxt = w_ovf_upd;
            end
         end
         ST_DONE: begin
            if (r_out_valid && bus.out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_state_nxt     = ST_ACCUM;
            end
         end
         default: begin
            w_state_nxt = ST_ACCUM;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_ACCUM;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_count <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_cnt       <= w_cnt_nxt;
         r_ovf       <= w_ovf_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_sum   <= w_out_sum_nxt;
         r_out_count <= w_out_count_nxt;
         r_out_ovf   <= w_out_ovf_nxt;
      end
   end

   assign bus.in_ready     = (r_state == ST_ACCUM);
   assign bus.out_valid    = r_out_valid;
   assign bus.out_sum      = r_out_sum;
   assign bus.out_count    = r_out_count;
   assign bus.out_overflow = r_out_ovf;

endmodule
